seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Parametrised multiplexed 7-segment display driver that replaces the per-service anode/segment update logic in `Main`. It accepts an N-digit hex/BCD value with per-digit decimal-point, blank and blink masks, and time-multiplexes it onto shared segment lines. New values are latched only at frame boundaries, so the display never tears. Optional leading-zero suppression is built in. Service modules (time set, alarm set, stopwatch) drive its inputs; its outputs go straight to the board pins.

## Interface
- `N_DIGITS`, default 4: number of digits, legal range 2..8.
- `SCAN_DIV`, default 50000: `clk_osc` cycles per digit slot, minimum 2.
- `BLINK_FRAMES`, default 64: frames per blink half-period, minimum 1.
- `LZ_BLANK`, default 1: 1 enables leading-zero suppression.
- `ACTIVE_LOW`, default 1: 1 means `anode` and `eSeg` are active-low (board default); 0 means active-high.
- `clk_osc` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `digits` in 4*N_DIGITS: digit values; nibble i is digit i, and digit 0 is the rightmost.
- `dp` in N_DIGITS: decimal point per digit.
- `blank_mask` in N_DIGITS: 1 forces that digit dark.
- `blink_mask` in N_DIGITS: 1 makes that digit blink.
- `load` in 1: update request; the inputs are sampled on any cycle `load`=1.
- `anode` out N_DIGITS: one-hot digit select, registered.
- `eSeg` out 8: segment lines, registered; bit 7 = dp, bits 6..0 = g,f,e,d,c,b,a.
- `frame_start` out 1: one-cycle pulse when the scan returns to digit 0.

## Operation
- **Prescaler** `pre`:
  - Counts 0..SCAN_DIV-1 and wraps.
  - `tick` is asserted on the cycle `pre`=SCAN_DIV-1.
- **Scan index** `idx`:
  - Counts 0..N_DIGITS-1 and advances on `tick`.
  - Wraps N_DIGITS-1 → 0.
  - That wrap is the frame boundary `fb`.
- **Double buffer.** There is a shadow register set (digits, dp, blank_mask, blink_mask), an active register set, and a `pending` flag.
  - `load`=1, not on `fb`: shadow ← inputs, `pending` ← 1. Last load wins.
  - On `fb` with `load`=1: active ← inputs directly, `pending` ← 0.
  - On `fb` with `load`=0 and `pending`=1: active ← shadow, `pending` ← 0.
  - Otherwise active holds.
- **Blink.** A frame counter counts 0..BLINK_FRAMES-1 on `fb`. On wrap, `phase` toggles.
  - While `phase`=1, digits with their active blink bit set are dark, dp included.
- **Leading-zero suppression** (LZ_BLANK=1):
  - Digit i (i ≥ 1) is suppressed when it and every more-significant active nibble are 0.
  - Digit 0 is never suppressed.
  - A suppressed digit still shows its dp.
- **Dark priority.** A digit is dark if any of the following holds: `blank_mask`, active blink, or LZ suppression (dp exempt for LZ only).
- **Decode**, gfedcba, in logical polarity:
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110.
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
  - A = 1110111, b = 1111100, C = 0111001, d = 1011110, E = 1111001, F = 1110001.
- **Output polarity.** Exactly one `anode` bit is logically active: bit `idx`. When ACTIVE_LOW=1, all outputs are inverted.
- **Reset** (asynchronous):
  - `pre`, `idx`, frame counter, `phase`, `pending`, shadow and active registers all go to 0.
  - `anode` goes all-inactive, `eSeg` all-off, `frame_start` = 0.
- **Reset mid-operation.** Discard the pending load. The display restarts from digit 0 showing "0" (digit 0 only when LZ_BLANK=1; all zeros when LZ_BLANK=0).

## Timing
- Outputs are registered and reflect `idx` and the active set one cycle after they change.
- First cycle after reset release: digit 0 is driven.
- `frame_start` goes high on the cycle after `fb`, the same cycle `anode` switches to digit 0.
- Frame length is N_DIGITS*SCAN_DIV cycles. Each digit is lit for exactly SCAN_DIV consecutive cycles.
- Load-to-display latency:
  - A `load` sampled on a `fb` cycle appears 1 cycle later.
  - Otherwise it appears at the next `fb` + 1, worst case N_DIGITS*SCAN_DIV cycles.
- Blink half-period is BLINK_FRAMES frames. `phase` changes only at a frame boundary.

## Test plan
All scenarios use N_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=1.
1. **Reset and scan.** Release reset with no loads. `anode` sequence is 1110, 1101, 1011, 0111, each held 4 cycles, repeating. `eSeg` = 11000000 on digit 0 and 11111111 on digits 1-3 (LZ). `frame_start` pulses every 16 cycles.
2. **Frame-boundary latch.**
   - Load `digits`=16'h1234 mid-frame; digits stay dark/"0" until the next `fb`, then show 4, 3, 2, 1 on digits 0..3.
   - Load 16'h5678 then 16'h9ABC within the same frame; only 9ABC is ever displayed.
3. **Load on `fb` cycle.** Assert `load` on the `fb` cycle with 16'h00F0. From the next cycle, digit 1 shows F (eSeg 10001110), digit 2 and digit 3 are dark, digit 0 shows 0.
4. **Blink and blank.** Load `blink_mask`=0001, `dp`=0001, `digits`=16'h0008.
   - Digit 0 shows 00000000 (lit with dp) for 2 frames, then 11111111 for 2 frames.
   - `blank_mask`=0001 keeps it dark permanently.
5. **Reset mid-load.** Load 16'hFFFF at pre=1, idx=2, then pulse `reset` before `fb`. After release, `pending` is discarded and the display shows "0" on digit 0 only.
6. **LZ dp and disable.**
   - Load `digits`=16'h0005, `dp`=0100. Digit 2 shows only the dp (eSeg 01111111).
   - Rebuild with LZ_BLANK=0: the same stimulus shows 0, 0., 0, 5 across digits 3..0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with frame-synchronous double buffering,
// per-digit blank/blink/dp masks and optional leading-zero suppression.
module seg_scan_driver #(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int LZ_BLANK     = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk_osc,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  load,
  output logic [N_DIGITS-1:0]   anode,
  output logic [7:0]            eSeg,
  output logic                  frame_start
);

  localparam int DW = 4 * N_DIGITS;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);
  localparam logic          POL     = (ACTIVE_LOW != 0);

  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  logic [PW-1:0]       pre_q, pre_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [FW-1:0]       frm_q, frm_d;
  logic                phase_q, phase_d;
  logic                pend_q, pend_d;
  logic [DW-1:0]       sh_dig_q, sh_dig_d, act_dig_q, act_dig_d;
  logic [N_DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0] sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic [N_DIGITS-1:0] sh_blink_q, sh_blink_d, act_blink_q, act_blink_d;
  logic [N_DIGITS-1:0] anode_q, anode_d;
  logic [7:0]          eseg_q, eseg_d;
  logic                fs_q;
  logic                tick, fb;

  // Scan timing, blink phase and the shadow/active double buffer
  always_comb begin
    tick        = (pre_q == PRE_MAX);
    fb          = tick && (idx_q == IDX_MAX);
    pre_d       = tick ? '0 : pre_q + 1'b1;
    idx_d       = idx_q;
    frm_d       = frm_q;
    phase_d     = phase_q;
    pend_d      = pend_q;
    sh_dig_d    = sh_dig_q;
    sh_dp_d     = sh_dp_q;
    sh_blank_d  = sh_blank_q;
    sh_blink_d  = sh_blink_q;
    act_dig_d   = act_dig_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    act_blink_d = act_blink_q;
    if (tick) idx_d = fb ? '0 : idx_q + 1'b1;
    if (fb) begin
      if (frm_q == FRM_MAX) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
      pend_d = 1'b0;
      // A load coinciding with the boundary bypasses the shadow entirely
      if (load) begin
        act_dig_d   = digits;
        act_dp_d    = dp;
        act_blank_d = blank_mask;
        act_blink_d = blink_mask;
      end else if (pend_q) begin
        act_dig_d   = sh_dig_q;
        act_dp_d    = sh_dp_q;
        act_blank_d = sh_blank_q;
        act_blink_d = sh_blink_q;
      end
    end else if (load) begin
      sh_dig_d   = digits;
      sh_dp_d    = dp;
      sh_blank_d = blank_mask;
      sh_blink_d = blink_mask;
      pend_d     = 1'b1;
    end
  end

  logic [3:0]          nib;
  logic                sel_dp, sel_blank, sel_blink, sel_lz, hi_zero, dark;
  logic [6:0]          seg_lit;
  logic [N_DIGITS-1:0] an_log;

  // Output stage looks at next-state values so pins change on the same edge as idx
  always_comb begin
    nib       = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    sel_blink = 1'b0;
    sel_lz    = 1'b0;
    hi_zero   = 1'b1;
    an_log    = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      hi_zero = hi_zero & (act_dig_d[4*i +: 4] == 4'd0);
      if (idx_d == IW'(i)) begin
        nib       = act_dig_d[4*i +: 4];
        sel_dp    = act_dp_d[i];
        sel_blank = act_blank_d[i];
        sel_blink = act_blink_d[i];
        sel_lz    = hi_zero & (i != 0) & (LZ_BLANK != 0);
        an_log[i] = 1'b1;
      end
    end
    dark    = sel_blank | (phase_d & sel_blink);
    seg_lit = (dark | sel_lz) ? 7'd0 : dec7(nib);
    eseg_d  = {~dark & sel_dp, seg_lit} ^ {8{POL}};
    anode_d = an_log ^ {N_DIGITS{POL}};
  end

  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      pre_q       <= '0;
      idx_q       <= '0;
      frm_q       <= '0;
      phase_q     <= 1'b0;
      pend_q      <= 1'b0;
      sh_dig_q    <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      sh_blink_q  <= '0;
      act_dig_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      act_blink_q <= '0;
      anode_q     <= {N_DIGITS{POL}};
      eseg_q      <= {8{POL}};
      fs_q        <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      frm_q       <= frm_d;
      phase_q     <= phase_d;
      pend_q      <= pend_d;
      sh_dig_q    <= sh_dig_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      sh_blink_q  <= sh_blink_d;
      act_dig_q   <= act_dig_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      act_blink_q <= act_blink_d;
      anode_q     <= anode_d;
      eseg_q      <= eseg_d;
      fs_q        <= fb;
    end
  end

  assign anode       = anode_q;
  assign eSeg        = eseg_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (LZ on / LZ off) checked every cycle
// against a frame-level model, plus hand-computed pin values.
module tb_seg_scan_driver;
  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int P  = N * SD;

  logic        clk_osc = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0, blank_mask = '0, blink_mask = '0;
  logic        load = 1'b0;
  logic [3:0]  an_a, an_b;
  logic [7:0]  sg_a, sg_b;
  logic        fs_a, fs_b;

  always #5 clk_osc = ~clk_osc;

  seg_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZ_BLANK(1), .ACTIVE_LOW(1)) dut (
    .clk_osc(clk_osc), .reset(reset), .digits(digits), .dp(dp), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .load(load), .anode(an_a), .eSeg(sg_a), .frame_start(fs_a));

  seg_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZ_BLANK(0), .ACTIVE_LOW(1)) dut_nlz (
    .clk_osc(clk_osc), .reset(reset), .digits(digits), .dp(dp), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .load(load), .anode(an_b), .eSeg(sg_b), .frame_start(fs_b));

  // clock edges since reset release
  int ecnt = 0;
  always @(posedge clk_osc or posedge reset)
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;

  int nvec = 0, nmis = 0;

  int          lg_edge [64];
  logic [15:0] lg_dig [64];
  logic [3:0]  lg_dp [64], lg_bl [64], lg_bk [64];
  int          nlog = 0;

  logic [6:0] seg_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                               7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  task automatic model(input int k, input bit lz, output logic [3:0] an,
                       output logic [7:0] sg, output logic fs);
    logic [15:0] d;
    logic [3:0]  p, bl, bk;
    logic [7:0]  lgc;
    int          dg, fcount;
    bit          ph, sup, dark;
    d = '0; p = '0; bl = '0; bk = '0;
    if (k == 0) begin
      an = 4'hF; sg = 8'hFF; fs = 1'b0;
      return;
    end
    fcount = k / P;
    for (int i = 0; i < nlog; i++)
      if (fcount > 0 && lg_edge[i] <= fcount * P) begin
        d = lg_dig[i]; p = lg_dp[i]; bl = lg_bl[i]; bk = lg_bk[i];
      end
    dg   = (k / SD) % N;
    ph   = ((fcount / BF) % 2) == 1;
    sup  = lz && dg >= 1 && ((d >> (4 * dg)) == 16'd0);
    dark = bl[dg] || (ph && bk[dg]);
    lgc  = {dark ? 1'b0 : p[dg], (dark || sup) ? 7'd0 : seg_tab[d[4*dg +: 4]]};
    an   = ~(4'b0001 << dg);
    sg   = ~lgc;
    fs   = (k % P) == 0;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  int         pin_seq = 0, pin_seen = 0;
  string      pin_tag;
  bit         pin_w;
  logic [3:0] pin_an;
  logic [7:0] pin_sg;

  always @(negedge clk_osc) begin
    logic [3:0] ea;
    logic [7:0] es;
    logic       ef;
    model(ecnt, 1'b1, ea, es, ef);
    chk("anode_lz", {4'h0, an_a}, {4'h0, ea});
    chk("eSeg_lz", sg_a, es);
    chk("frame_start_lz", {7'd0, fs_a}, {7'd0, ef});
    model(ecnt, 1'b0, ea, es, ef);
    chk("anode_nlz", {4'h0, an_b}, {4'h0, ea});
    chk("eSeg_nlz", sg_b, es);
    chk("frame_start_nlz", {7'd0, fs_b}, {7'd0, ef});
    if (pin_seq != pin_seen) begin
      pin_seen = pin_seq;
      chk({pin_tag, "_anode"}, {4'h0, pin_w ? an_b : an_a}, {4'h0, pin_an});
      chk({pin_tag, "_eSeg"}, pin_w ? sg_b : sg_a, pin_sg);
    end
  end

  task automatic pin(input string tag, input bit w, input logic [3:0] an, input logic [7:0] sg);
    pin_tag = tag; pin_w = w; pin_an = an; pin_sg = sg;
    pin_seq++;
    @(negedge clk_osc); #1;
  endtask

  task automatic tick_to(input int m);
    int n = 0;
    do begin
      @(posedge clk_osc); #1;
      n++;
    end while ((ecnt % P) != m && n < 64);
    if ((ecnt % P) != m) begin
      $display("FAIL tick_to: slot %0d not reached, at %0d", m, ecnt % P);
      $fatal(1, "scan position never reached");
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] bl,
                         input logic [3:0] bk);
    digits = d; dp = p; blank_mask = bl; blink_mask = bk;
    load = 1'b1;
    @(posedge clk_osc); #1;
    load = 1'b0;
    lg_edge[nlog] = ecnt; lg_dig[nlog] = d; lg_dp[nlog] = p; lg_bl[nlog] = bl; lg_bk[nlog] = bk;
    nlog++;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    load  = 1'b0;
    nlog  = 0;
    pin("rst_hold", 1'b0, 4'hF, 8'hFF);
    pin("rst_hold2", 1'b0, 4'hF, 8'hFF);
    reset = 1'b0;
  endtask

  initial begin
    // reset and idle scan
    pin("reset", 1'b0, 4'hF, 8'hFF);
    reset = 1'b0;
    tick_to(2);  pin("idle_d0", 1'b0, 4'b1110, 8'hC0);
    tick_to(6);  pin("idle_d1", 1'b0, 4'b1101, 8'hFF);
    tick_to(14); pin("idle_d3", 1'b0, 4'b0111, 8'hFF);
    tick_to(2);  pin("idle_nlz_d0", 1'b1, 4'b1110, 8'hC0);

    // mid-frame load latched only at the boundary
    tick_to(5);  do_load(16'h1234, 4'h0, 4'h0, 4'h0);
    tick_to(10); pin("pre_fb_d2", 1'b0, 4'b1011, 8'hFF);
    tick_to(2);  pin("1234_d0", 1'b0, 4'b1110, 8'h99);
    tick_to(14); pin("1234_d3", 1'b0, 4'b0111, 8'hF9);
    tick_to(5);  do_load(16'h5678, 4'h0, 4'h0, 4'h0);
    tick_to(9);  do_load(16'h9ABC, 4'h0, 4'h0, 4'h0);
    tick_to(2);  pin("9ABC_d0", 1'b0, 4'b1110, 8'hC6);

    // load on the boundary cycle itself
    tick_to(15); do_load(16'h00F0, 4'h0, 4'h0, 4'h0);
    pin("fb_load_d0", 1'b0, 4'b1110, 8'hC0);
    tick_to(4);  pin("fb_load_d1", 1'b0, 4'b1101, 8'h8E);
    tick_to(8);  pin("fb_load_d2", 1'b0, 4'b1011, 8'hFF);

    // blink then blank
    tick_to(5);  do_load(16'h0008, 4'b0001, 4'b0000, 4'b0001);
    for (int f = 0; f < 5; f++) begin
      tick_to(2);
      pin("blink_d0", 1'b0, 4'b1110, ((((ecnt / P) / BF) % 2) == 1) ? 8'hFF : 8'h00);
    end
    tick_to(5);  do_load(16'h0008, 4'b0001, 4'b0001, 4'b0001);
    for (int f = 0; f < 4; f++) begin
      tick_to(2);
      pin("blank_d0", 1'b0, 4'b1110, 8'hFF);
    end

    // reset with a load still pending
    tick_to(9);  do_load(16'hFFFF, 4'h0, 4'h0, 4'h0);
    pulse_reset();
    tick_to(2);  pin("post_rst_d0", 1'b0, 4'b1110, 8'hC0);
    tick_to(6);  pin("post_rst_d1", 1'b0, 4'b1101, 8'hFF);
    tick_to(2);  pin("post_rst_next_d0", 1'b0, 4'b1110, 8'hC0);
    tick_to(14); pin("post_rst_d3", 1'b0, 4'b0111, 8'hFF);

    // leading-zero dp, with and without suppression
    tick_to(5);  do_load(16'h0005, 4'b0100, 4'b0000, 4'b0000);
    tick_to(2);  pin("lz_d0", 1'b0, 4'b1110, 8'h92);
    tick_to(10); pin("lz_d2_dp", 1'b0, 4'b1011, 8'h7F);
    tick_to(10); pin("nlz_d2", 1'b1, 4'b1011, 8'h40);
    tick_to(14); pin("nlz_d3", 1'b1, 4'b0111, 8'hC0);
    tick_to(14); pin("lz_d3", 1'b0, 4'b0111, 8'hFF);

    repeat (3) @(negedge clk_osc);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
